game_round_ctrl: RTL and testbench
==================================

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 8: number of rounds per game (1..15).
REQ-002 Parameter MAX_MISS, default 3: misses that end the game early (1..15).
REQ-003 Parameter WAIT_MIN_MS, default 500: minimum pre-cue delay, in ticks.
REQ-004 Parameter CUE_TIMEOUT_MS, default 1000: reaction window, in ticks (<=1023).
REQ-005 Parameter RESULT_MS, default 500: post-round display hold, in ticks.
REQ-006 clk  in  1  single system clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 i_tick  in  1  1 ms strobe, one clk wide.
REQ-009 i_start  in  1  one-shot start event, one clk wide.
REQ-010 i_restart  in  1  one-shot restart event, one clk wide.
REQ-011 i_play  in  2  one-shot play events; bit0 = left, bit1 = right.
REQ-012 o_cue  out  2  registered cue LEDs, one-hot or zero; bit0 = left, bit1 = right.
REQ-013 o_state  out  3  current state: IDLE=0, WAIT=1, CUE=2, RESULT=3, OVER=4.
REQ-014 o_score  out  4  hit count for the current game.
REQ-015 o_react_ms  out  10  reaction time of the last hit, in ticks.
REQ-016 o_hit / o_miss  out  1 each  one-clk pulses on round outcome.
REQ-017 o_game_over  out  1  high while in OVER.

Function
REQ-018 All state and outputs are registered; every response appears the clk after the causing input.
REQ-019 An 8-bit LFSR (taps 8,6,5,4; seed 8'hA5) advances every clk and never reaches zero.
REQ-020 i_restart is accepted in any state and has priority over every other input: it clears score, round and miss counters and o_react_ms, drives o_cue to 0, and enters IDLE.
REQ-021 IDLE: i_start clears the counters and enters WAIT; i_play is ignored.
REQ-022 WAIT entry: latch the wait length WAIT_MIN_MS + 4*LFSR[6:0] ticks; on expiry enter CUE.
REQ-023 CUE entry: set o_cue to 2'b01 if LFSR[7]=0, else 2'b10; clear the reaction counter.
REQ-024 CUE: the reaction counter increments on each i_tick and saturates at 1023.
REQ-025 CUE, exactly one i_play bit set, matching o_cue: o_hit pulses; score +1 (saturating at 15); o_react_ms <= counter; enter RESULT.
REQ-026 CUE, wrong bit or both bits set: o_miss pulses; misses +1; o_react_ms unchanged; enter RESULT.
REQ-027 CUE, counter reaches CUE_TIMEOUT_MS with no press: o_miss pulses and the block enters RESULT; a press in the same clk as the timeout is evaluated as a press.
REQ-028 Every exit from CUE increments the round counter and clears o_cue.
REQ-029 RESULT: hold for RESULT_MS ticks, ignoring i_play; then enter OVER if rounds == ROUNDS or misses == MAX_MISS, else WAIT.
REQ-030 OVER: o_game_over = 1; score and o_react_ms hold; only i_restart leaves OVER.
REQ-031 i_start outside IDLE is ignored.
REQ-032 An i_tick coincident with a state transition counts toward the new state's timer only.

Reset
REQ-033 While rst_n = 0: state IDLE, o_cue = 0, o_score = 0, o_react_ms = 0, o_hit = o_miss = o_game_over = 0, all counters 0, LFSR = 8'hA5.
REQ-034 Reset asserted mid-game aborts immediately with no o_hit or o_miss pulse.

Configuration
REQ-035 Macro GAME_EARLY_PENALTY_EN defined: any i_play in WAIT pulses o_miss, increments misses and the round counter, and enters RESULT.
REQ-036 Macro GAME_EARLY_PENALTY_EN undefined: i_play in WAIT is ignored.

Verification
REQ-037 Reset, i_start, forced LFSR[7]=0, i_play=01 after 123 ticks in CUE -> o_hit pulse, o_score=1, o_react_ms=123, state 3.
REQ-038 In CUE with o_cue=10, i_play=11 -> o_miss pulse, o_score unchanged, state RESULT.
REQ-039 No press for 1000 ticks in CUE -> o_miss on timeout; after 3 misses and RESULT hold -> o_game_over=1, state 4.
REQ-040 8 consecutive hits -> o_score=8, state OVER; i_start ignored; i_restart -> state 0, o_score=0.
REQ-041 i_restart and i_play asserted in the same clk during CUE -> IDLE, no o_hit or o_miss.
REQ-042 i_play during WAIT: with GAME_EARLY_PENALTY_EN -> o_miss and state RESULT; without it -> state stays WAIT.

Source files
------------

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - reaction game round sequencer: random wait, cue, hit/miss scoring
// Optional feature macro: GAME_EARLY_PENALTY_EN (a press during the pre-cue wait counts as a miss).
module game_round_ctrl #(
  parameter int ROUNDS         = 8,
  parameter int MAX_MISS       = 3,
  parameter int WAIT_MIN_MS    = 500,
  parameter int CUE_TIMEOUT_MS = 1000,
  parameter int RESULT_MS      = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic       i_restart,
  input  logic [1:0] i_play,
  output logic [1:0] o_cue,
  output logic [2:0] o_state,
  output logic [3:0] o_score,
  output logic [9:0] o_react_ms,
  output logic       o_hit,
  output logic       o_miss,
  output logic       o_game_over
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_CUE    = 3'd2,
    S_RESULT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [15:0] WAIT_MIN_T = 16'(WAIT_MIN_MS);
  localparam logic [15:0] RESULT_T   = 16'(RESULT_MS);
  localparam logic [9:0]  TIMEOUT_T  = 10'(CUE_TIMEOUT_MS);
  localparam logic [3:0]  ROUNDS_T   = 4'(ROUNDS);
  localparam logic [3:0]  MAX_MISS_T = 4'(MAX_MISS);

  state_t      state, state_nx;
  logic [7:0]  lfsr, lfsr_nx;
  logic [15:0] wait_len, wait_len_nx;
  logic [15:0] timer, timer_nx;
  logic [9:0]  react_cnt, react_cnt_nx;
  logic [3:0]  score, score_nx;
  logic [3:0]  round_cnt, round_cnt_nx;
  logic [3:0]  miss_cnt, miss_cnt_nx;
  logic [1:0]  cue, cue_nx;
  logic [9:0]  react_ms, react_ms_nx;
  logic        hit, hit_nx;
  logic        miss, miss_nx;
  logic        game_over, game_over_nx;

  logic [15:0] timer_start;
  logic [9:0]  react_start;
  logic [15:0] wait_len_rand;
  logic [3:0]  miss_inc;
  logic [3:0]  round_inc;

  // A tick landing on a transition clk is credited to the state being entered.
  assign timer_start   = {15'd0, i_tick};
  assign react_start   = {9'd0, i_tick};
  assign wait_len_rand = WAIT_MIN_T + {7'd0, lfsr[6:0], 2'b00};
  assign miss_inc      = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;
  assign round_inc     = (round_cnt == 4'hF) ? round_cnt : round_cnt + 4'd1;

  always_comb begin
    state_nx     = state;
    lfsr_nx      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    wait_len_nx  = wait_len;
    timer_nx     = timer;
    react_cnt_nx = react_cnt;
    score_nx     = score;
    round_cnt_nx = round_cnt;
    miss_cnt_nx  = miss_cnt;
    cue_nx       = cue;
    react_ms_nx  = react_ms;
    hit_nx       = 1'b0;
    miss_nx      = 1'b0;

    if (i_restart) begin
      state_nx     = S_IDLE;
      timer_nx     = '0;
      react_cnt_nx = '0;
      score_nx     = '0;
      round_cnt_nx = '0;
      miss_cnt_nx  = '0;
      cue_nx       = '0;
      react_ms_nx  = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            state_nx     = S_WAIT;
            score_nx     = '0;
            round_cnt_nx = '0;
            miss_cnt_nx  = '0;
            wait_len_nx  = wait_len_rand;
            timer_nx     = timer_start;
          end
        end

        S_WAIT: begin
`ifdef GAME_EARLY_PENALTY_EN
          if (|i_play) begin
            state_nx     = S_RESULT;
            miss_nx      = 1'b1;
            miss_cnt_nx  = miss_inc;
            round_cnt_nx = round_inc;
            timer_nx     = timer_start;
          end else
`endif
          if (timer >= wait_len) begin
            state_nx     = S_CUE;
            cue_nx       = lfsr[7] ? 2'b10 : 2'b01;
            react_cnt_nx = react_start;
          end else if (i_tick) begin
            timer_nx = timer + 16'd1;
          end
        end

        S_CUE: begin
          // A press on the timeout clk wins over the timeout.
          if (|i_play) begin
            state_nx     = S_RESULT;
            cue_nx       = '0;
            round_cnt_nx = round_inc;
            timer_nx     = timer_start;
            if (i_play == cue) begin
              hit_nx      = 1'b1;
              score_nx    = (score == 4'hF) ? score : score + 4'd1;
              react_ms_nx = react_cnt;
            end else begin
              miss_nx     = 1'b1;
              miss_cnt_nx = miss_inc;
            end
          end else if (react_cnt >= TIMEOUT_T) begin
            state_nx     = S_RESULT;
            cue_nx       = '0;
            round_cnt_nx = round_inc;
            timer_nx     = timer_start;
            miss_nx      = 1'b1;
            miss_cnt_nx  = miss_inc;
          end else if (i_tick && (react_cnt != 10'h3FF)) begin
            react_cnt_nx = react_cnt + 10'd1;
          end
        end

        S_RESULT: begin
          if (timer >= RESULT_T) begin
            if ((round_cnt == ROUNDS_T) || (miss_cnt == MAX_MISS_T)) begin
              state_nx = S_OVER;
            end else begin
              state_nx    = S_WAIT;
              wait_len_nx = wait_len_rand;
              timer_nx    = timer_start;
            end
          end else if (i_tick) begin
            timer_nx = timer + 16'd1;
          end
        end

        S_OVER: begin
          state_nx = S_OVER;
        end

        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end

    game_over_nx = (state_nx == S_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lfsr      <= 8'hA5;
      wait_len  <= '0;
      timer     <= '0;
      react_cnt <= '0;
      score     <= '0;
      round_cnt <= '0;
      miss_cnt  <= '0;
      cue       <= '0;
      react_ms  <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      lfsr      <= lfsr_nx;
      wait_len  <= wait_len_nx;
      timer     <= timer_nx;
      react_cnt <= react_cnt_nx;
      score     <= score_nx;
      round_cnt <= round_cnt_nx;
      miss_cnt  <= miss_cnt_nx;
      cue       <= cue_nx;
      react_ms  <= react_ms_nx;
      hit       <= hit_nx;
      miss      <= miss_nx;
      game_over <= game_over_nx;
    end
  end

  assign o_state     = state;
  assign o_cue       = cue;
  assign o_score     = score;
  assign o_react_ms  = react_ms;
  assign o_hit       = hit;
  assign o_miss      = miss;
  assign o_game_over = game_over;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - directed self-checking bench for game_round_ctrl
// Builds with or without GAME_EARLY_PENALTY_EN; the early-press expectation follows the macro.
module tb_game_round_ctrl;

  localparam int WAIT_MIN  = 10;
  localparam int RES_HOLD  = 5;
  localparam int TIMEOUT   = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_tick, i_start, i_restart;
  logic [1:0] i_play;
  logic [1:0] o_cue;
  logic [2:0] o_state;
  logic [3:0] o_score;
  logic [9:0] o_react_ms;
  logic       o_hit, o_miss, o_game_over;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_len  = 0;
  logic [7:0] m_lfsr;
  logic [1:0] ecue;

  game_round_ctrl #(
    .ROUNDS(8), .MAX_MISS(3), .WAIT_MIN_MS(WAIT_MIN),
    .CUE_TIMEOUT_MS(TIMEOUT), .RESULT_MS(RES_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_start(i_start),
    .i_restart(i_restart), .i_play(i_play), .o_cue(o_cue), .o_state(o_state),
    .o_score(o_score), .o_react_ms(o_react_ms), .o_hit(o_hit), .o_miss(o_miss),
    .o_game_over(o_game_over)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8 + x^6 + x^5 + x^4 + 1, seed A5, one step per clk.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      i_tick = 1'b1;
      step();
    end
    i_tick = 1'b0;
  endtask

  task automatic start_game();
    exp_len = WAIT_MIN + 4 * int'(m_lfsr[6:0]);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic finish_result();
    tick_n(RES_HOLD);
    exp_len = WAIT_MIN + 4 * int'(m_lfsr[6:0]);
    step();
  endtask

  // want: 0 = left cue, 1 = right cue, 2 = whatever the LFSR gives.
  task automatic enter_cue(input int want, output logic [1:0] cue_exp);
    int guard;
    tick_n(exp_len - 1);
    guard = 0;
    if (want < 2) begin
      while ((m_lfsr[6] != (want == 1)) && (guard < 20)) begin
        step();
        guard++;
      end
      check_eq("cue_select_bound", guard < 20, 1);
    end
    cue_exp = m_lfsr[6] ? 2'b10 : 2'b01;
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    check_eq("wait_not_expired", o_state, 1);
    step();
    check_eq("cue_state", o_state, 2);
    check_eq("cue_value", o_cue, cue_exp);
  endtask

  task automatic do_hit(input logic [1:0] cue_exp, input int react, input int exp_score);
    tick_n(react);
    i_play = cue_exp;
    step();
    i_play = 2'b00;
    check_eq("hit_pulse", o_hit, 1);
    check_eq("hit_no_miss", o_miss, 0);
    check_eq("hit_score", o_score, exp_score);
    check_eq("hit_react", o_react_ms, react);
    check_eq("hit_state", o_state, 3);
    check_eq("hit_cue_clear", o_cue, 0);
  endtask

  task automatic timeout_round();
    tick_n(TIMEOUT);
    check_eq("to_still_cue", o_state, 2);
    check_eq("to_no_early_miss", o_miss, 0);
    step();
    check_eq("to_miss", o_miss, 1);
    check_eq("to_state", o_state, 3);
    check_eq("to_cue_clear", o_cue, 0);
  endtask

  initial begin
    rst_n = 1'b0; i_tick = 1'b0; i_start = 1'b0; i_restart = 1'b0; i_play = 2'b00;
    step(); step();
    check_eq("rst_state", o_state, 0);
    check_eq("rst_cue", o_cue, 0);
    check_eq("rst_score", o_score, 0);
    check_eq("rst_react", o_react_ms, 0);
    check_eq("rst_hit", o_hit, 0);
    check_eq("rst_miss", o_miss, 0);
    check_eq("rst_over", o_game_over, 0);
    rst_n = 1'b1;
    step();

    i_play = 2'b01;
    step();
    i_play = 2'b00;
    check_eq("idle_play_ignored", o_state, 0);

    // Game 1: hit, double-press miss, early press, timeouts until three misses.
    start_game();
    check_eq("start_wait", o_state, 1);
    enter_cue(0, ecue);
    check_eq("forced_left", o_cue, 2'b01);
    do_hit(ecue, 123, 1);
    step();
    check_eq("hit_one_clk", o_hit, 0);
    finish_result();
    check_eq("res_to_wait", o_state, 1);

    enter_cue(1, ecue);
    i_play = 2'b11;
    step();
    i_play = 2'b00;
    check_eq("both_miss", o_miss, 1);
    check_eq("both_no_hit", o_hit, 0);
    check_eq("both_score", o_score, 1);
    check_eq("both_react_held", o_react_ms, 123);
    check_eq("both_state", o_state, 3);
    i_play = 2'b01;
    step();
    i_play = 2'b00;
    check_eq("result_play_ignored", o_miss, 0);
    finish_result();

    i_play = 2'b01;
    step();
    i_play = 2'b00;
`ifdef GAME_EARLY_PENALTY_EN
    check_eq("early_miss", o_miss, 1);
    check_eq("early_state", o_state, 3);
    finish_result();
    enter_cue(2, ecue);
    timeout_round();
`else
    check_eq("early_no_miss", o_miss, 0);
    check_eq("early_state", o_state, 1);
    enter_cue(2, ecue);
    timeout_round();
    finish_result();
    enter_cue(2, ecue);
    timeout_round();
`endif
    finish_result();
    check_eq("over_state", o_state, 4);
    check_eq("over_flag", o_game_over, 1);
    check_eq("over_score", o_score, 1);
    check_eq("over_react", o_react_ms, 123);
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    check_eq("restart1_state", o_state, 0);
    check_eq("restart1_react", o_react_ms, 0);

    // Game 2: eight hits; the last lands on the timeout clk.
    start_game();
    for (int k = 0; k < 8; k++) begin
      enter_cue(2, ecue);
      do_hit(ecue, (k == 7) ? TIMEOUT : 7 + 3 * k, k + 1);
      finish_result();
      check_eq("g2_after_round", o_state, (k == 7) ? 4 : 1);
    end
    check_eq("g2_score", o_score, 8);
    check_eq("g2_over", o_game_over, 1);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check_eq("over_start_ignored", o_state, 4);
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    check_eq("restart2_state", o_state, 0);
    check_eq("restart2_score", o_score, 0);
    check_eq("restart2_over", o_game_over, 0);

    // Restart beats a simultaneous correct press.
    start_game();
    enter_cue(2, ecue);
    tick_n(3);
    i_restart = 1'b1;
    i_play = ecue;
    step();
    i_restart = 1'b0;
    i_play = 2'b00;
    check_eq("prio_state", o_state, 0);
    check_eq("prio_no_hit", o_hit, 0);
    check_eq("prio_no_miss", o_miss, 0);
    check_eq("prio_cue", o_cue, 0);

    // Asynchronous reset mid-cue.
    start_game();
    enter_cue(2, ecue);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", o_state, 0);
    check_eq("async_rst_cue", o_cue, 0);
    check_eq("async_rst_hit", o_hit, 0);
    check_eq("async_rst_miss", o_miss, 0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_idle", o_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
